// File: rtl/periph_bus_fabric.sv
// periph_bus_fabric: FemtoRV32 memory port to N peripheral slots plus RAM.
// Each slot owns one 64 KiB page starting at PAGE_BASE; everything else is RAM.
// Slot accesses stall the CPU until the slave raises ready, or until a timeout
// returns ERR_DATA and records the first failing address.
// Optional macro PERIPH_BUS_ERRCNT_EN adds a saturating timeout counter output.
module periph_bus_fabric #(
    parameter int          N_SLV     = 6,
    parameter logic [15:0] PAGE_BASE = 16'h0040,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'h66666666
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cpu_addr,
    input  logic                 cpu_rstrb,
    input  logic [3:0]           cpu_wmask,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_rbusy,
    output logic                 cpu_wbusy,
    output logic                 ram_cs,
    input  logic [31:0]          ram_rdata,
    output logic [N_SLV-1:0]     slv_cs,
    input  logic [32*N_SLV-1:0]  slv_rdata,
    input  logic [N_SLV-1:0]     slv_ready,
    input  logic                 err_clr,
    output logic                 err_flag,
    output logic [31:0]          err_addr
`ifdef PERIPH_BUS_ERRCNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam int SLOT_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               dir_q, dir_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_flag_q, err_flag_d;
    logic [31:0]        err_addr_q, err_addr_d;
`ifdef PERIPH_BUS_ERRCNT_EN
    logic [7:0]         err_count_q, err_count_d;
`endif

    logic [15:0]        page_idx;
    logic               page_hit;
    logic [SLOT_W-1:0]  dec_slot;
    logic               req;
    logic               req_wr;
    logic               sel_ready;
    logic [31:0]        sel_rdata;

    // Page decode of the live CPU address; an underflowing subtraction is a RAM address
    always_comb begin
        page_idx = cpu_addr[31:16] - PAGE_BASE;
        page_hit = (cpu_addr[31:16] >= PAGE_BASE) && (page_idx < 16'(N_SLV));
        dec_slot = page_idx[SLOT_W-1:0];
        req      = cpu_rstrb | (|cpu_wmask);
        req_wr   = |cpu_wmask;
    end

    // Pick ready and read data of the latched slot; other slots' ready is ignored
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[32*i +: 32];
            end
        end
    end

    // Next-state logic: latch slot requests, wait for ready or time out
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        slot_d     = slot_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_flag_d = err_clr ? 1'b0 : err_flag_q;
        err_addr_d = err_addr_q;
`ifdef PERIPH_BUS_ERRCNT_EN
        err_count_d = err_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req && page_hit) begin
                    state_d = ST_WAIT;
                    addr_d  = cpu_addr;
                    slot_d  = dec_slot;
                    dir_d   = req_wr;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (sel_ready) begin
                    if (!dir_q) begin
                        rdata_d = sel_rdata;
                    end
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    if (!dir_q) begin
                        rdata_d = ERR_DATA;
                    end
                    // A timeout coinciding with a clear is treated as a fresh first error
                    if (!err_flag_q || err_clr) begin
                        err_flag_d = 1'b1;
                        err_addr_d = addr_q;
                    end
`ifdef PERIPH_BUS_ERRCNT_EN
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
`endif
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            slot_q     <= '0;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
`ifdef PERIPH_BUS_ERRCNT_EN
            err_count_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            slot_q     <= slot_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
`ifdef PERIPH_BUS_ERRCNT_EN
            err_count_q <= err_count_d;
`endif
        end
    end

    // Output steering: live decode in IDLE, latched slot and stall while waiting
    always_comb begin
        cpu_rbusy = 1'b0;
        cpu_wbusy = 1'b0;
        ram_cs    = 1'b0;
        slv_cs    = '0;
        cpu_rdata = rdata_q;
        if (state_q == ST_IDLE) begin
            ram_cs = !page_hit;
            if (req && page_hit) begin
                cpu_rbusy = !req_wr;
                cpu_wbusy = req_wr;
            end
            if (!page_hit) begin
                cpu_rdata = ram_rdata;
            end
            for (int i = 0; i < N_SLV; i++) begin
                slv_cs[i] = page_hit && (dec_slot == SLOT_W'(i));
            end
        end else begin
            cpu_rbusy = !dir_q;
            cpu_wbusy = dir_q;
            for (int i = 0; i < N_SLV; i++) begin
                slv_cs[i] = (slot_q == SLOT_W'(i));
            end
        end
    end

    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;
`ifdef PERIPH_BUS_ERRCNT_EN
    assign err_count = err_count_q;
`endif

endmodule
